// File: rtl/timer_pkg.sv
// Shared encodings and defaults for the MM:SS countdown timer control block.
// State encoding is exposed on the debug LEDs, so the numeric values are fixed.
package timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        DONE  = ST_DONE
    } state_t;

    localparam int CLK_HZ_DEFAULT       = 50_000_000;
    localparam int DEBOUNCE_CYC_DEFAULT = 1_000_000;
    localparam int BLINK_CYC_DEFAULT    = 25_000_000;

    // Largest number of minutes a single add press may request.
    localparam logic [3:0] ADD_MIN_MAX = 4'd9;

    function automatic logic [3:0] clamp_minutes(input logic [3:0] sw);
        return (sw > ADD_MIN_MAX) ? ADD_MIN_MAX : sw;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces one raw active-low key and emits a 1-cycle pulse on each accepted press.
// Latency: DEBOUNCE_CYC+3 cycles from a stable raw edge to the press pulse.
// No backpressure: the pulse is fire-and-forget; releases produce no event.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic key_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_prev;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_a     <= 1'b1;
            sync_b     <= 1'b1;
            level      <= 1'b1;
            level_prev <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync_a     <= key_raw;
            sync_b     <= sync_a;
            level_prev <= level;
            press      <= level_prev & ~level;
            // Any sample matching the accepted level restarts the stability window.
            if (sync_b == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                stable_cnt <= '0;
                level      <= sync_b;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer control: key events, 1 Hz prescaler, expiry blink and datapath strobes.
// Latency: every strobe and state change is registered one cycle after its causing event.
// No backpressure: the digit datapath must accept each 1-cycle strobe as issued.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int BLINK_CYC    = BLINK_CYC_DEFAULT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] KEY,
    input  logic [3:0] Switch,
    input  logic       cnt_zero,
    output logic       cnt_dec,
    output logic       cnt_add,
    output logic [3:0] cnt_add_val,
    output logic       cnt_clr,
    output logic       blank,
    output logic       running,
    output logic [1:0] state
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int BW = $clog2(BLINK_CYC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    logic start_evt;
    logic add_press;
    logic add_evt;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_start (
        .Clock   (Clock),
        .Reset   (Reset),
        .key_raw (KEY[0]),
        .press   (start_evt)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_add (
        .Clock   (Clock),
        .Reset   (Reset),
        .key_raw (KEY[1]),
        .press   (add_press)
    );

    // Start/stop wins a same-cycle collision; the add press is discarded.
    assign add_evt = add_press & ~start_evt;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          blank_d;
    logic          dec_d;
    logic          add_d;
    logic          clr_d;
    logic [3:0]    add_val_d;
    logic          running_d;
    logic          tick;

    assign tick  = (presc_q == PRESC_LAST);
    assign state = state_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            blink_q     <= '0;
            blank       <= 1'b0;
            cnt_dec     <= 1'b0;
            cnt_add     <= 1'b0;
            cnt_clr     <= 1'b0;
            cnt_add_val <= 4'd0;
            running     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_q     <= blink_d;
            blank       <= blank_d;
            cnt_dec     <= dec_d;
            cnt_add     <= add_d;
            cnt_clr     <= clr_d;
            cnt_add_val <= add_val_d;
            running     <= running_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        blink_d   = blink_q;
        blank_d   = blank;
        dec_d     = 1'b0;
        add_d     = 1'b0;
        clr_d     = 1'b0;
        add_val_d = cnt_add_val;

        case (state_q)
            IDLE: begin
                blank_d = 1'b0;
                if (start_evt) begin
                    // Starting an empty timer is silently ignored.
                    if (!cnt_zero) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end else if (add_evt) begin
                    add_d     = 1'b1;
                    add_val_d = clamp_minutes(Switch);
                end
            end

            RUN: begin
                // Expiry outranks the tick so 00:00 is never decremented.
                if (cnt_zero) begin
                    state_d = DONE;
                    blink_d = '0;
                    blank_d = 1'b1;
                end else if (start_evt) begin
                    state_d = PAUSE;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    dec_d   = tick;
                end
            end

            PAUSE: begin
                if (start_evt) begin
                    state_d = RUN;
                end else if (add_evt) begin
                    add_d     = 1'b1;
                    add_val_d = clamp_minutes(Switch);
                end
            end

            DONE: begin
                if (start_evt) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                    blank_d = 1'b0;
                end else if (add_evt) begin
                    state_d   = IDLE;
                    add_d     = 1'b1;
                    add_val_d = clamp_minutes(Switch);
                    blank_d   = 1'b0;
                end else if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    blank_d = ~blank;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        running_d = (state_d == RUN);
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with small timing parameters.
// Stimulus queues expected strobes; a negedge monitor pops and checks them.
module tb_timer_ctrl;
    import timer_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [1:0] KEY;
    logic [3:0] Switch;
    logic       cnt_zero;
    logic       cnt_dec;
    logic       cnt_add;
    logic [3:0] cnt_add_val;
    logic       cnt_clr;
    logic       blank;
    logic       running;
    logic [1:0] state;

    timer_ctrl #(.CLK_HZ(10), .DEBOUNCE_CYC(4), .BLINK_CYC(5)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .KEY         (KEY),
        .Switch      (Switch),
        .cnt_zero    (cnt_zero),
        .cnt_dec     (cnt_dec),
        .cnt_add     (cnt_add),
        .cnt_add_val (cnt_add_val),
        .cnt_clr     (cnt_clr),
        .blank       (blank),
        .running     (running),
        .state       (state)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] kind;
        logic [3:0] val;
        int         at;
    } exp_t;

    localparam logic [2:0] K_DEC = 3'b100;
    localparam logic [2:0] K_ADD = 3'b010;
    localparam logic [2:0] K_CLR = 3'b001;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_evt(input logic [2:0] k, input logic [3:0] v, input int c);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.at   = c;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard in kind, cycle and value.
    always @(negedge Clock) begin
        logic [2:0] obs;
        exp_t       e;
        obs = {cnt_dec, cnt_add, cnt_clr};
        if (obs != 3'b000) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {29'd0, obs}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", {29'd0, obs}, {29'd0, e.kind});
                chk("strobe_cycle", cyc, e.at);
                if (e.kind == K_ADD)
                    chk("add_val", {28'd0, cnt_add_val}, {28'd0, e.val});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, k, e_run, m, p, r, rr, d, q, q2, q3, b;
        KEY      = 2'b11;
        Switch   = 4'd0;
        cnt_zero = 1'b0;
        Reset    = 1'b1;

        at(3);
        chk("rst_state", {30'd0, state}, {30'd0, ST_IDLE});
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_blank", {31'd0, blank}, 32'd0);
        chk("rst_add_val", {28'd0, cnt_add_val}, 32'd0);
        chk("rst_strobes", {29'd0, cnt_dec, cnt_add, cnt_clr}, 32'd0);
        Reset = 1'b0;

        // Clean start press, then async reset while the prescaler sits at 6.
        t = 6;
        expect_evt(K_DEC, 4'd0, t + 18);
        expect_evt(K_DEC, 4'd0, t + 28);
        at(t);
        KEY[0] = 1'b0;
        at(t + 7);
        chk("start_not_early", {30'd0, state}, {30'd0, ST_IDLE});
        at(t + 8);
        chk("start_run", {30'd0, state}, {30'd0, ST_RUN});
        chk("start_running", {31'd0, running}, 32'd1);
        KEY[0] = 1'b1;
        at(t + 34);
        Reset = 1'b1;
        at(t + 35);
        chk("midrun_rst_state", {30'd0, state}, {30'd0, ST_IDLE});
        chk("midrun_rst_running", {31'd0, running}, 32'd0);
        chk("midrun_rst_blank", {31'd0, blank}, 32'd0);
        chk("midrun_rst_strobes", {29'd0, cnt_dec, cnt_add, cnt_clr}, 32'd0);
        at(t + 36);
        Reset = 1'b0;

        // Bouncy start press: 1-0-1-0 then held low.
        k = t + 40;
        e_run = k + 10;
        expect_evt(K_DEC, 4'd0, e_run + 10);
        expect_evt(K_DEC, 4'd0, e_run + 20);
        at(k);
        KEY[0] = 1'b0;
        at(k + 1);
        KEY[0] = 1'b1;
        at(k + 2);
        KEY[0] = 1'b0;
        at(k + 9);
        chk("bounce_not_early", {30'd0, state}, {30'd0, ST_IDLE});
        at(k + 10);
        chk("bounce_run", {30'd0, state}, {30'd0, ST_RUN});
        at(k + 12);
        KEY[0] = 1'b1;

        // Pause with the prescaler held at 2.
        m = k + 25;
        at(m);
        KEY[0] = 1'b0;
        at(m + 8);
        chk("pause_state", {30'd0, state}, {30'd0, ST_PAUSE});
        chk("pause_running", {31'd0, running}, 32'd0);
        KEY[0] = 1'b1;

        // Add in PAUSE with an out-of-range switch value.
        p = m + 12;
        Switch = 4'hC;
        expect_evt(K_ADD, 4'd9, p + 8);
        at(p);
        KEY[1] = 1'b0;
        at(p + 8);
        chk("pause_add_state", {30'd0, state}, {30'd0, ST_PAUSE});
        KEY[1] = 1'b1;

        // Resume: prescaler continues from 2, so the first decrement is 8 cycles later.
        r = p + 12;
        rr = r + 8;
        expect_evt(K_DEC, 4'd0, rr + 8);
        at(r);
        KEY[0] = 1'b0;
        at(r + 8);
        chk("resume_run", {30'd0, state}, {30'd0, ST_RUN});
        KEY[0] = 1'b1;

        // cnt_zero rises in the tick cycle: DONE without a decrement.
        at(rr + 17);
        cnt_zero = 1'b1;
        d = rr + 18;
        for (int i = 0; i <= 10; i++) begin
            at(d + i);
            chk("blink", {31'd0, blank}, (i < 5 || i == 10) ? 32'd1 : 32'd0);
        end
        chk("done_state", {30'd0, state}, {30'd0, ST_DONE});
        chk("done_running", {31'd0, running}, 32'd0);

        q = d + 12;
        expect_evt(K_CLR, 4'd0, q + 8);
        at(q);
        KEY[0] = 1'b0;
        at(q + 8);
        chk("clr_state", {30'd0, state}, {30'd0, ST_IDLE});
        chk("clr_blank", {31'd0, blank}, 32'd0);
        KEY[0] = 1'b1;

        // Start with the counter already at zero is ignored.
        q2 = q + 20;
        at(q2);
        KEY[0] = 1'b0;
        at(q2 + 8);
        KEY[0] = 1'b1;
        at(q2 + 10);
        chk("zero_start_idle", {30'd0, state}, {30'd0, ST_IDLE});

        // Add in IDLE with an in-range switch value.
        q3 = q2 + 20;
        Switch = 4'd3;
        expect_evt(K_ADD, 4'd3, q3 + 8);
        at(q3);
        KEY[1] = 1'b0;
        at(q3 + 8);
        chk("idle_add_state", {30'd0, state}, {30'd0, ST_IDLE});
        KEY[1] = 1'b1;
        cnt_zero = 1'b0;

        // Both keys together: start wins, no add.
        b = q3 + 20;
        expect_evt(K_DEC, 4'd0, b + 18);
        at(b);
        KEY = 2'b00;
        at(b + 8);
        chk("both_keys_run", {30'd0, state}, {30'd0, ST_RUN});
        KEY = 2'b11;

        at(b + 22);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
